// File: rtl/vending_pkg.sv
// ============================================================================
// vending_pkg : coin constants, denomination codes and dispenser state type
// Revision    : 1.0
// ============================================================================
`default_nettype none

package vending_pkg;

    localparam int COIN_5  = 5;
    localparam int COIN_10 = 10;

    localparam logic DEN_5  = 1'b0;
    localparam logic DEN_10 = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        ISSUE = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } disp_state_t;

endpackage

`default_nettype wire

// File: rtl/change_check.sv
// ============================================================================
// change_check : greedy feasibility test of a change amount against hopper stock
// Revision     : 1.0
// ============================================================================
`default_nettype none

module change_check
    import vending_pkg::*;
#(
    parameter int AMT_W   = 5,
    parameter int STOCK_W = 4
) (
    input  logic [AMT_W-1:0]   rem,
    input  logic [STOCK_W-1:0] stock10,
    input  logic [STOCK_W-1:0] stock5,
    output logic               ok,
    output logic               is_zero
);

    // One bit of headroom over the amount, widened further if stock is wider.
    localparam int CW = ((AMT_W + 1) > STOCK_W) ? (AMT_W + 1) : STOCK_W;

    localparam logic [CW-1:0] c_ten  = CW'(COIN_10);
    localparam logic [CW-1:0] c_five = CW'(COIN_5);

    logic [CW-1:0] w_rem;
    logic [CW-1:0] w_s10;
    logic [CW-1:0] w_s5;
    logic [CW-1:0] w_q10;
    logic [CW-1:0] w_n10;
    logic [CW-1:0] w_rest;
    logic [CW-1:0] w_n5;

    assign w_rem  = CW'(rem);
    assign w_s10  = CW'(stock10);
    assign w_s5   = CW'(stock5);
    assign w_q10  = w_rem / c_ten;
    assign w_n10  = (w_q10 < w_s10) ? w_q10 : w_s10;
    assign w_rest = w_rem - (w_n10 * c_ten);
    assign w_n5   = w_rest / c_five;

    assign ok      = ((w_rem % c_five) == '0) && (w_n5 <= w_s5);
    assign is_zero = (rem == '0);

endmodule

`default_nettype wire

// File: rtl/change_dispenser.sv
// ============================================================================
// change_dispenser : pays out change one coin at a time from 10/5-unit hoppers
// Revision         : 1.0
// ============================================================================
`default_nettype none

module change_dispenser
    import vending_pkg::*;
#(
    parameter int AMT_W        = 5,
    parameter int STOCK_W      = 4,
    parameter int STOCK10_INIT = 8,
    parameter int STOCK5_INIT  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    input  logic [AMT_W-1:0]   req_amount,
    output logic               req_ready,
    output logic               coin_valid,
    output logic               coin_den,
    input  logic               coin_ack,
    output logic               done,
    output logic               err,
    input  logic               refill,
    output logic [STOCK_W-1:0] stock10,
    output logic [STOCK_W-1:0] stock5
);

    localparam logic [AMT_W-1:0]   c_amt10  = AMT_W'(COIN_10);
    localparam logic [AMT_W-1:0]   c_amt5   = AMT_W'(COIN_5);
    localparam logic [STOCK_W-1:0] c_init10 = STOCK_W'(STOCK10_INIT);
    localparam logic [STOCK_W-1:0] c_init5  = STOCK_W'(STOCK5_INIT);
    localparam logic [STOCK_W-1:0] c_one    = STOCK_W'(1);

    disp_state_t        r_state;
    disp_state_t        w_next;
    logic [AMT_W-1:0]   r_rem;
    logic [STOCK_W-1:0] r_stock10;
    logic [STOCK_W-1:0] r_stock5;

    logic               w_is_issue;
    logic               w_take10;
    logic               w_xfer;
    logic [AMT_W-1:0]   w_rem_after;
    logic               w_ok;
    logic               w_zero;

    change_check #(
        .AMT_W   (AMT_W),
        .STOCK_W (STOCK_W)
    ) u_check (
        .rem     (r_rem),
        .stock10 (r_stock10),
        .stock5  (r_stock5),
        .ok      (w_ok),
        .is_zero (w_zero)
    );

    // Denomination derives only from registered rem/stock, so it holds while stalled.
    assign w_is_issue  = (r_state == ISSUE);
    assign w_take10    = w_is_issue && (r_rem >= c_amt10) && (r_stock10 != '0);
    assign w_xfer      = w_is_issue && coin_ack;
    assign w_rem_after = r_rem - (w_take10 ? c_amt10 : c_amt5);

    assign req_ready  = (r_state == IDLE);
    assign coin_valid = w_is_issue;
    assign coin_den   = w_take10 ? DEN_10 : DEN_5;
    assign done       = (r_state == DONE);
    assign err        = (r_state == ERR);
    assign stock10    = r_stock10;
    assign stock5     = r_stock5;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (req_valid) w_next = CHECK;
            CHECK: begin
                if (!w_ok)       w_next = ERR;
                else if (w_zero) w_next = DONE;
                else             w_next = ISSUE;
            end
            ISSUE:   if (w_xfer && (w_rem_after == '0)) w_next = DONE;
            DONE:    w_next = IDLE;
            ERR:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem     <= '0;
            r_stock10 <= c_init10;
            r_stock5  <= c_init5;
        end else begin
            if (r_state == IDLE) begin
                if (refill) begin
                    r_stock10 <= c_init10;
                    r_stock5  <= c_init5;
                end
                if (req_valid) begin
                    r_rem <= req_amount;
                end
            end else if (w_xfer) begin
                r_rem <= w_rem_after;
                if (w_take10) begin
                    r_stock10 <= r_stock10 - c_one;
                end else begin
                    r_stock5 <= r_stock5 - c_one;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_change_dispenser.sv
// ============================================================================
// tb_change_dispenser : scoreboard bench, default-stock DUT plus a 1/1-stock DUT
// Revision            : 1.0
// ============================================================================
`default_nettype none

module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       a_req_valid = 1'b0, b_req_valid = 1'b0;
    logic [4:0] a_req_amount = '0,  b_req_amount = '0;
    logic       a_coin_ack = 1'b1,  b_coin_ack = 1'b1;
    logic       a_refill = 1'b0,    b_refill = 1'b0;
    logic       a_req_ready, a_coin_valid, a_coin_den, a_done, a_err;
    logic       b_req_ready, b_coin_valid, b_coin_den, b_done, b_err;
    logic [3:0] a_stock10, a_stock5, b_stock10, b_stock5;

    int n_vec = 0;
    int n_err = 0;

    // Event codes in the scoreboard: 0 = 5-unit coin, 1 = 10-unit coin, 2 = done, 3 = err
    int qa[$];
    int qb[$];
    int m10[2];
    int m5[2];
    int init10[2] = '{8, 1};
    int init5[2]  = '{8, 1};

    always #5 clk = ~clk;

    change_dispenser #(.AMT_W(5), .STOCK_W(4), .STOCK10_INIT(8), .STOCK5_INIT(8)) u_dut_a (
        .clk(clk), .rst(rst), .req_valid(a_req_valid), .req_amount(a_req_amount),
        .req_ready(a_req_ready), .coin_valid(a_coin_valid), .coin_den(a_coin_den),
        .coin_ack(a_coin_ack), .done(a_done), .err(a_err), .refill(a_refill),
        .stock10(a_stock10), .stock5(a_stock5)
    );

    change_dispenser #(.AMT_W(5), .STOCK_W(4), .STOCK10_INIT(1), .STOCK5_INIT(1)) u_dut_b (
        .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_amount(b_req_amount),
        .req_ready(b_req_ready), .coin_valid(b_coin_valid), .coin_den(b_coin_den),
        .coin_ack(b_coin_ack), .done(b_done), .err(b_err), .refill(b_refill),
        .stock10(b_stock10), .stock5(b_stock5)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic sb_pop(input int sel, input int got, input string tag);
        int e;
        e = -1;
        if (sel == 0) begin
            if (qa.size() > 0) e = qa.pop_front();
        end else begin
            if (qb.size() > 0) e = qb.pop_front();
        end
        chk(tag, got, e);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (a_coin_valid && a_coin_ack) sb_pop(0, int'(a_coin_den), "a_coin");
            if (a_done) sb_pop(0, 2, "a_done");
            if (a_err)  sb_pop(0, 3, "a_err");
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (b_coin_valid && b_coin_ack) sb_pop(1, int'(b_coin_den), "b_coin");
            if (b_done) sb_pop(1, 2, "b_done");
            if (b_err)  sb_pop(1, 3, "b_err");
        end
    end

    // Greedy payout model: tens first, capped by stock, remainder in fives.
    task automatic push_exp(input int sel, input int amt, input bit rf);
        int s10, s5, n10, n5;
        int ev[$];
        if (rf) begin
            m10[sel] = init10[sel];
            m5[sel]  = init5[sel];
        end
        s10 = m10[sel];
        s5  = m5[sel];
        n10 = ((amt / 10) < s10) ? (amt / 10) : s10;
        n5  = (amt - 10 * n10) / 5;
        if ((amt % 5) != 0 || n5 > s5) begin
            ev.push_back(3);
        end else begin
            repeat (n10) ev.push_back(1);
            repeat (n5)  ev.push_back(0);
            ev.push_back(2);
            m10[sel] = s10 - n10;
            m5[sel]  = s5 - n5;
        end
        foreach (ev[k]) begin
            if (sel == 0) qa.push_back(ev[k]);
            else          qb.push_back(ev[k]);
        end
    endtask

    // Returns just after the accepting edge (edge 0).
    task automatic drive_req(input int sel, input int amt, input bit rf);
        push_exp(sel, amt, rf);
        @(posedge clk); #1;
        if (sel == 0) begin
            a_req_valid = 1'b1; a_req_amount = 5'(amt); a_refill = rf;
        end else begin
            b_req_valid = 1'b1; b_req_amount = 5'(amt);
        end
        @(posedge clk); #1;
        a_req_valid = 1'b0; a_refill = 1'b0;
        b_req_valid = 1'b0;
    endtask

    task automatic post_chk(input int sel);
        #1;
        if (sel == 0) begin
            chk("a_stock10", 32'(a_stock10), 32'(m10[0]));
            chk("a_stock5",  32'(a_stock5),  32'(m5[0]));
            chk("a_sb_empty", 32'(qa.size()), 0);
        end else begin
            chk("b_stock10", 32'(b_stock10), 32'(m10[1]));
            chk("b_stock5",  32'(b_stock5),  32'(m5[1]));
            chk("b_sb_empty", 32'(qb.size()), 0);
        end
    endtask

    task automatic wait_term(input int sel);
        int n;
        bit hit;
        n = 0;
        hit = 1'b0;
        while (!hit && n < 60) begin
            @(negedge clk);
            n++;
            hit = (sel == 0) ? (a_done || a_err) : (b_done || b_err);
        end
        if (!hit) chk("term_timeout", 0, 1);
        post_chk(sel);
    endtask

    initial begin
        m10 = init10;
        m5  = init5;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_ready",  32'(a_req_ready), 1);
        chk("rst_cvalid", 32'(a_coin_valid), 0);
        chk("rst_done",   32'(a_done), 0);
        chk("rst_err",    32'(a_err), 0);
        chk("rst_s10",    32'(a_stock10), 8);
        chk("rst_s5",     32'(a_stock5), 8);
        chk("rst_b_s10",  32'(b_stock10), 1);

        // 15 units: 10 in cycle 2, 5 in cycle 3, done in cycle 4
        drive_req(0, 15, 1'b0);
        @(negedge clk); chk("c15_c1_cv", 32'(a_coin_valid), 0);
        @(negedge clk); chk("c15_c2_cv", 32'(a_coin_valid), 1); chk("c15_c2_den", 32'(a_coin_den), 1);
        @(negedge clk); chk("c15_c3_cv", 32'(a_coin_valid), 1); chk("c15_c3_den", 32'(a_coin_den), 0);
        @(negedge clk); chk("c15_c4_done", 32'(a_done), 1);
        post_chk(0);
        chk("c15_s10", 32'(a_stock10), 7);
        @(negedge clk); chk("c15_ready", 32'(a_req_ready), 1);

        // Not a multiple of 5
        drive_req(0, 7, 1'b0);
        @(negedge clk);
        @(negedge clk); chk("c7_err", 32'(a_err), 1); chk("c7_cv", 32'(a_coin_valid), 0);
        post_chk(0);
        @(negedge clk); chk("c7_ready", 32'(a_req_ready), 1);

        // Zero amount: done in cycle 2
        drive_req(0, 0, 1'b0);
        @(negedge clk); chk("c0_c1_done", 32'(a_done), 0);
        @(negedge clk); chk("c0_c2_done", 32'(a_done), 1); chk("c0_c2_cv", 32'(a_coin_valid), 0);
        post_chk(0);

        // Hopper stalls 3 cycles; refill pulsed mid-issue must be ignored
        a_coin_ack = 1'b0;
        drive_req(0, 10, 1'b0);
        @(negedge clk);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_cv",  32'(a_coin_valid), 1);
            chk("stall_den", 32'(a_coin_den), 1);
            chk("stall_s10", 32'(a_stock10), 7);
            @(posedge clk); #1;
            a_refill = (i == 0);
            if (i == 2) a_coin_ack = 1'b1;
        end
        a_refill = 1'b0;
        wait_term(0);

        // Drain tens, then a request paid entirely in fives
        drive_req(0, 30, 1'b1); wait_term(0);
        drive_req(0, 30, 1'b0); wait_term(0);
        drive_req(0, 20, 1'b0); wait_term(0);
        chk("drain_s10", 32'(a_stock10), 0);
        drive_req(0, 20, 1'b0); wait_term(0);
        chk("fives_s5", 32'(a_stock5), 4);

        // Refill coincident with request: CHECK sees full stock
        drive_req(0, 20, 1'b1); wait_term(0);
        chk("refill_s10", 32'(a_stock10), 6);

        // Low-stock instance: 20 rejected, 15 paid exactly
        drive_req(1, 20, 1'b0); wait_term(1);
        drive_req(1, 15, 1'b0); wait_term(1);
        chk("b_empty10", 32'(b_stock10), 0);
        chk("b_empty5",  32'(b_stock5), 0);

        // Asynchronous reset while a coin is pending
        a_coin_ack = 1'b0;
        drive_req(0, 30, 1'b0);
        @(negedge clk);
        @(negedge clk); chk("rsti_cv_pre", 32'(a_coin_valid), 1);
        #2 rst = 1'b1;
        #1;
        chk("rsti_cv",    32'(a_coin_valid), 0);
        chk("rsti_ready", 32'(a_req_ready), 1);
        chk("rsti_s10",   32'(a_stock10), 8);
        chk("rsti_s5",    32'(a_stock5), 8);
        qa.delete();
        qb.delete();
        m10 = init10;
        m5  = init5;
        @(posedge clk); #1 rst = 1'b0;
        a_coin_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rsto_done",  32'(a_done), 0);
            chk("rsto_ready", 32'(a_req_ready), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
